// File: rtl/gerador_fruta.sv
// Fruit spawner: picks free map cells from an LFSR, writes the fruit,
// holds it until eaten and erases it when the game stops.
module gerador_fruta #(
  parameter int          MAPA_WIDTH     = 80,
  parameter int          MAPA_HEIGHT    = 60,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          MAX_TENTATIVAS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       comeu,
  input  logic       ocupado,
  output logic       fruta_read,
  output logic       fruta_write,
  output logic       fruta_dado,
  output logic [9:0] fruta_x,
  output logic [9:0] fruta_y,
  output logic       fruta_valid,
  output logic [9:0] fruta_pos_x,
  output logic [9:0] fruta_pos_y,
  output logic       falha
);

  localparam int CW = (MAPA_WIDTH  > 1) ? $clog2(MAPA_WIDTH)  : 1;
  localparam int CH = (MAPA_HEIGHT > 1) ? $clog2(MAPA_HEIGHT) : 1;
  localparam int TW = $clog2(MAX_TENTATIVAS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SORTEIA,
    S_CONSULTA,
    S_AGUARDA,
    S_ESCREVE,
    S_ATIVA,
    S_APAGA,
    S_ERRO
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_lfsr;
  logic [9:0]    r_cand_x;
  logic [9:0]    r_cand_y;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_inc;
  logic [9:0]    w_cand_x;
  logic [9:0]    w_cand_y;
  logic          w_cand_ok;

  assign w_cnt_inc = r_cnt + TW'(1);

  // Candidate cell from the current LFSR value, zero-extended to 10 bits
  always_comb begin
    w_cand_x = '0;
    w_cand_y = '0;
    w_cand_x[CW-1:0] = r_lfsr[CW-1:0];
    w_cand_y[CH-1:0] = r_lfsr[15 -: CH];
    w_cand_ok = ({1'b0, w_cand_x} < 11'(MAPA_WIDTH)) &&
                ({1'b0, w_cand_y} < 11'(MAPA_HEIGHT));
  end

  // Free-running Galois LFSR, mask 16'hB400
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_lfsr <= SEED;
    else if (r_lfsr[0])
      r_lfsr <= (r_lfsr >> 1) ^ 16'hB400;
    else
      r_lfsr <= r_lfsr >> 1;
  end

  // State, latched candidate and fruit position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      fruta_pos_x <= '0;
      fruta_pos_y <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_SORTEIA) begin
        r_cand_x <= w_cand_x;
        r_cand_y <= w_cand_y;
      end
      if (r_state == S_ESCREVE) begin
        fruta_pos_x <= r_cand_x;
        fruta_pos_y <= r_cand_y;
      end
    end
  end

  // Occupied-candidate counter; cleared on spawn and whenever we go idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (r_state == S_AGUARDA && enable && ocupado)
      r_cnt <= w_cnt_inc;
    else if (r_state == S_ESCREVE || w_next == S_IDLE)
      r_cnt <= '0;
  end

  // Next state and Moore outputs
  always_comb begin
    w_next      = r_state;
    fruta_read  = 1'b0;
    fruta_write = 1'b0;
    fruta_dado  = 1'b0;
    fruta_x     = '0;
    fruta_y     = '0;
    fruta_valid = 1'b0;
    falha       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_SORTEIA;
      end
      S_SORTEIA: begin
        if (!enable)        w_next = S_IDLE;
        else if (w_cand_ok) w_next = S_CONSULTA;
      end
      S_CONSULTA: begin
        fruta_read = 1'b1;
        fruta_x    = r_cand_x;
        fruta_y    = r_cand_y;
        w_next     = enable ? S_AGUARDA : S_IDLE;
      end
      S_AGUARDA: begin
        if (!enable)
          w_next = S_IDLE;
        else if (!ocupado)
          w_next = S_ESCREVE;
        else if (w_cnt_inc >= TW'(MAX_TENTATIVAS))
          w_next = S_ERRO;
        else
          w_next = S_SORTEIA;
      end
      S_ESCREVE: begin
        fruta_write = 1'b1;
        fruta_dado  = 1'b1;
        fruta_x     = r_cand_x;
        fruta_y     = r_cand_y;
        w_next      = S_ATIVA;
      end
      S_ATIVA: begin
        fruta_valid = 1'b1;
        if (!enable)    w_next = comeu ? S_IDLE : S_APAGA;
        else if (comeu) w_next = S_SORTEIA;
      end
      S_APAGA: begin
        fruta_write = 1'b1;
        fruta_x     = fruta_pos_x;
        fruta_y     = fruta_pos_y;
        w_next      = S_IDLE;
      end
      S_ERRO: begin
        falha = 1'b1;
        if (!enable) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gerador_fruta.sv
// Directed bench for gerador_fruta: spawn, retry, eat, erase,
// mid-query reset and exhaustion of free-cell attempts.
module tb_gerador_fruta;

  logic       clk = 1'b0;
  logic       reset, enable, comeu, ocupado;
  logic       fruta_read, fruta_write, fruta_dado;
  logic [9:0] fruta_x, fruta_y;
  logic       fruta_valid;
  logic [9:0] fruta_pos_x, fruta_pos_y;
  logic       falha;

  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int er_cnt = 0;
  int proto_err = 0;
  logic [9:0] rd_x, rd_y, wr_x, wr_y;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  gerador_fruta #(
    .MAPA_WIDTH(80), .MAPA_HEIGHT(60),
    .SEED(16'hACE1), .MAX_TENTATIVAS(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .comeu(comeu), .ocupado(ocupado),
    .fruta_read(fruta_read), .fruta_write(fruta_write),
    .fruta_dado(fruta_dado), .fruta_x(fruta_x), .fruta_y(fruta_y),
    .fruta_valid(fruta_valid),
    .fruta_pos_x(fruta_pos_x), .fruta_pos_y(fruta_pos_y),
    .falha(falha)
  );

  always #5 clk = ~clk;

  // Map-side monitor: counts strobes and records protocol violations
  always @(negedge clk) begin
    if (fruta_read) begin
      rd_cnt = rd_cnt + 1;
      rd_x = fruta_x;
      rd_y = fruta_y;
    end
    if (fruta_write) begin
      wr_cnt = wr_cnt + 1;
      wr_x = fruta_x;
      wr_y = fruta_y;
      if (!fruta_dado) er_cnt = er_cnt + 1;
    end
    if (fruta_read && fruta_write) proto_err = proto_err + 1;
    if (!fruta_read && !fruta_write && (fruta_x != 0 || fruta_y != 0))
      proto_err = proto_err + 1;
    if ((fruta_read && prev_rd) || (fruta_write && prev_wr))
      proto_err = proto_err + 1;
    prev_rd = fruta_read;
    prev_wr = fruta_write;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_read(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (fruta_read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_write(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (fruta_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; comeu = 1'b0; ocupado = 1'b0;
    tick(3);
    n_chk++;
    if ({fruta_read, fruta_write, fruta_dado, fruta_x, fruta_y} !== '0)
      $display("FAIL reset_strobes got=%b exp=0",
               {fruta_read, fruta_write, fruta_dado, fruta_x, fruta_y});
    else n_pass++;
    n_chk++;
    if ({fruta_valid, fruta_pos_x, fruta_pos_y, falha} !== '0)
      $display("FAIL reset_status got=%b exp=0",
               {fruta_valid, fruta_pos_x, fruta_pos_y, falha});
    else n_pass++;
  endtask

  task automatic test_spawn;
    bit ok;
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    reset = 1'b0; enable = 1'b1;
    wait_read(40, ok);
    n_chk++;
    if (!ok) $display("FAIL spawn_read_timeout got=none exp=read");
    else n_pass++;
    n_chk++;
    if (fruta_x !== 10'd56 || fruta_y !== 10'd28)
      $display("FAIL spawn_first_cand got=(%0d,%0d) exp=(56,28)",
               fruta_x, fruta_y);
    else n_pass++;
    tick(1);
    n_chk++;
    if (fruta_write !== 1'b0)
      $display("FAIL spawn_early_write got=%b exp=0", fruta_write);
    else n_pass++;
    tick(1);
    n_chk++;
    if (fruta_write !== 1'b1 || fruta_dado !== 1'b1 ||
        fruta_x !== 10'd56 || fruta_y !== 10'd28)
      $display("FAIL spawn_write got=w%b d%b (%0d,%0d) exp=w1 d1 (56,28)",
               fruta_write, fruta_dado, fruta_x, fruta_y);
    else n_pass++;
    tick(1);
    n_chk++;
    if (fruta_valid !== 1'b1 || fruta_pos_x !== 10'd56 ||
        fruta_pos_y !== 10'd28)
      $display("FAIL spawn_valid got=v%b (%0d,%0d) exp=v1 (56,28)",
               fruta_valid, fruta_pos_x, fruta_pos_y);
    else n_pass++;
    n_chk++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1)
      $display("FAIL spawn_counts got=r%0d w%0d exp=r1 w1",
               rd_cnt - r0, wr_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_comeu;
    bit ok;
    logic [9:0] px = fruta_pos_x;
    logic [9:0] py = fruta_pos_y;
    int w0 = wr_cnt;
    int e0 = er_cnt;
    comeu = 1'b1;
    tick(1);
    comeu = 1'b0;
    n_chk++;
    if (fruta_valid !== 1'b0 || fruta_write !== 1'b0)
      $display("FAIL eat_drop got=v%b w%b exp=v0 w0",
               fruta_valid, fruta_write);
    else n_pass++;
    wait_write(400, ok);
    n_chk++;
    if (!ok || fruta_dado !== 1'b1)
      $display("FAIL eat_respawn got=ok%0d d%b exp=ok1 d1", ok, fruta_dado);
    else n_pass++;
    n_chk++;
    if (fruta_x == px && fruta_y == py)
      $display("FAIL eat_new_cell got=(%0d,%0d) exp=not (%0d,%0d)",
               fruta_x, fruta_y, px, py);
    else n_pass++;
    tick(1);
    n_chk++;
    if (fruta_valid !== 1'b1 || fruta_pos_x !== wr_x ||
        fruta_pos_y !== wr_y)
      $display("FAIL eat_pos got=v%b (%0d,%0d) exp=v1 (%0d,%0d)",
               fruta_valid, fruta_pos_x, fruta_pos_y, wr_x, wr_y);
    else n_pass++;
    n_chk++;
    if (er_cnt != e0 || wr_cnt - w0 != 1)
      $display("FAIL eat_writes got=e%0d w%0d exp=e0 w1",
               er_cnt - e0, wr_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_retry;
    bit ok;
    logic [9:0] ax, ay;
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    ocupado = 1'b1;
    comeu = 1'b1;
    tick(1);
    comeu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_read(400, ok);
      n_chk++;
      if (!ok) $display("FAIL retry_read%0d got=none exp=read", i);
      else n_pass++;
      if (i == 3) begin
        ocupado = 1'b0;
        ax = fruta_x;
        ay = fruta_y;
      end
    end
    wait_write(400, ok);
    n_chk++;
    if (!ok || fruta_x !== ax || fruta_y !== ay)
      $display("FAIL retry_cell got=(%0d,%0d) exp=(%0d,%0d)",
               fruta_x, fruta_y, ax, ay);
    else n_pass++;
    n_chk++;
    if (rd_cnt - r0 != 4 || wr_cnt - w0 != 1 || falha !== 1'b0)
      $display("FAIL retry_counts got=r%0d w%0d f%b exp=r4 w1 f0",
               rd_cnt - r0, wr_cnt - w0, falha);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_erase;
    logic [9:0] px = fruta_pos_x;
    logic [9:0] py = fruta_pos_y;
    int r0 = rd_cnt;
    int e0 = er_cnt;
    enable = 1'b0;
    tick(1);
    n_chk++;
    if (fruta_write !== 1'b1 || fruta_dado !== 1'b0 ||
        fruta_x !== px || fruta_y !== py)
      $display("FAIL erase_write got=w%b d%b (%0d,%0d) exp=w1 d0 (%0d,%0d)",
               fruta_write, fruta_dado, fruta_x, fruta_y, px, py);
    else n_pass++;
    tick(1);
    n_chk++;
    if (fruta_write !== 1'b0 || fruta_valid !== 1'b0)
      $display("FAIL erase_idle got=w%b v%b exp=w0 v0",
               fruta_write, fruta_valid);
    else n_pass++;
    tick(4);
    n_chk++;
    if (rd_cnt != r0 || er_cnt - e0 != 1)
      $display("FAIL erase_counts got=r%0d e%0d exp=r0 e1",
               rd_cnt - r0, er_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    ocupado = 1'b0;
    enable = 1'b1;
    wait_read(400, ok);
    n_chk++;
    if (!ok || fruta_pos_x == 0)
      $display("FAIL mid_setup got=ok%0d pos%0d exp=ok1 pos!=0",
               ok, fruta_pos_x);
    else n_pass++;
    reset = 1'b1;
    tick(1);
    n_chk++;
    if ({fruta_read, fruta_write, fruta_dado, fruta_x, fruta_y,
         fruta_valid, fruta_pos_x, fruta_pos_y, falha} !== '0)
      $display("FAIL mid_reset_outputs got=%b exp=0",
               {fruta_read, fruta_write, fruta_dado, fruta_x, fruta_y,
                fruta_valid, fruta_pos_x, fruta_pos_y, falha});
    else n_pass++;
    tick(1);
    reset = 1'b0;
    wait_read(40, ok);
    n_chk++;
    if (!ok || fruta_x !== 10'd56 || fruta_y !== 10'd28)
      $display("FAIL mid_seed_cand got=(%0d,%0d) exp=(56,28)",
               fruta_x, fruta_y);
    else n_pass++;
    wait_write(10, ok);
    tick(1);
    n_chk++;
    if (!ok || fruta_valid !== 1'b1)
      $display("FAIL mid_respawn got=ok%0d v%b exp=ok1 v1",
               ok, fruta_valid);
    else n_pass++;
  endtask

  task automatic test_falha;
    bit ok = 1'b0;
    int r0, w0;
    enable = 1'b0;
    tick(2);
    ocupado = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (falha) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) $display("FAIL falha_timeout got=0 exp=1");
    else n_pass++;
    n_chk++;
    if (rd_cnt - r0 != 64 || wr_cnt != w0)
      $display("FAIL falha_counts got=r%0d w%0d exp=r64 w0",
               rd_cnt - r0, wr_cnt - w0);
    else n_pass++;
    tick(5);
    n_chk++;
    if (falha !== 1'b1 || rd_cnt - r0 != 64)
      $display("FAIL falha_sticky got=f%b r%0d exp=f1 r64",
               falha, rd_cnt - r0);
    else n_pass++;
    enable = 1'b0;
    tick(1);
    n_chk++;
    if (falha !== 1'b0)
      $display("FAIL falha_clear got=%b exp=0", falha);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int w0 = wr_cnt;
    ocupado = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 63; i++) begin
      wait_read(400, ok);
      if (!ok) break;
      if (i == 62) ocupado = 1'b0;
    end
    n_chk++;
    if (!ok) $display("FAIL b2b_reads got=timeout exp=63 reads");
    else n_pass++;
    wait_write(10, ok);
    n_chk++;
    if (!ok || fruta_dado !== 1'b1 || falha !== 1'b0 ||
        fruta_x !== rd_x || fruta_y !== rd_y)
      $display("FAIL b2b_spawn got=ok%0d d%b f%b exp=ok1 d1 f0",
               ok, fruta_dado, falha);
    else n_pass++;
    n_chk++;
    if (wr_cnt - w0 != 1)
      $display("FAIL b2b_writes got=%0d exp=1", wr_cnt - w0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_comeu();
    test_retry();
    test_erase();
    test_reset_mid();
    test_falha();
    test_back_to_back();
    n_chk++;
    if (proto_err != 0)
      $display("FAIL protocol got=%0d violations exp=0", proto_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
